// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, default baud settings and a
// width helper used by the TX serializer and its baud counter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_e;

    localparam int DEFAULT_CLK_HZ       = 50_000_000;
    localparam int DEFAULT_BAUD         = 115200;
    localparam int DEFAULT_CLKS_PER_BIT = DEFAULT_CLK_HZ / DEFAULT_BAUD;

    // Counter/index width that never collapses to zero bits.
    function automatic int min1_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: fires tick on the last cycle of each bit period and
// restarts from zero whenever the owning FSM changes state.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
)(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick,
    output logic pre_tick
);

    localparam int CNT_W = min1_clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] PRE_LAST_CNT =
        CNT_W'((CLKS_PER_BIT > 1) ? (CLKS_PER_BIT - 2) : 0);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    assign tick = (cnt_reg == LAST_CNT);
    // High when tick will fire on the following cycle (barring a clear).
    assign pre_tick = (CLKS_PER_BIT == 1) || (cnt_reg == PRE_LAST_CNT);

    always_comb begin
        cnt_next = cnt_reg + 1'b1;
        if (clr || tick) begin
            cnt_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/uart_fifo_tx.sv
// UART transmit serializer draining a FIFO read port: pops one word per frame
// and shifts it out as start bit, DATASIZE data bits LSB first, one stop bit.
module uart_fifo_tx
    import uart_pkg::*;
#(
    parameter int DATASIZE     = 8,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
)(
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic                rempty,
    input  logic [DATASIZE-1:0] rdata,
    input  logic                tx_en,
    output logic                rinc,
    output logic                txd,
    output logic                busy,
    output logic                tx_done
);

    localparam int IDX_W = min1_clog2(DATASIZE);
    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATASIZE - 1);

    tx_state_e           state_reg, state_next;
    logic [DATASIZE-1:0] shreg_reg, shreg_next, shreg_shift;
    logic [IDX_W-1:0]    bit_idx_reg, bit_idx_next;
    logic                txd_reg, txd_next;
    logic                rinc_reg, rinc_next;
    logic                busy_reg, busy_next;
    logic                tx_done_reg, tx_done_next;
    logic                tick, pre_tick, state_chg;

    assign state_chg   = (state_next != state_reg);
    assign shreg_shift = shreg_reg >> 1;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (rclk),
        .rst_n   (rrst_n),
        .clr     (state_chg),
        .tick    (tick),
        .pre_tick(pre_tick)
    );

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_reg   <= IDLE;
            shreg_reg   <= '0;
            bit_idx_reg <= '0;
            txd_reg     <= 1'b1;
            rinc_reg    <= 1'b0;
            busy_reg    <= 1'b0;
            tx_done_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            shreg_reg   <= shreg_next;
            bit_idx_reg <= bit_idx_next;
            txd_reg     <= txd_next;
            rinc_reg    <= rinc_next;
            busy_reg    <= busy_next;
            tx_done_reg <= tx_done_next;
        end
    end

    // Leaving IDLE on the pop edge keeps the stale rempty from being resampled.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (tx_en && !rempty)                 state_next = START;
            START:   if (tick)                             state_next = DATA;
            DATA:    if (tick && bit_idx_reg == LAST_BIT)  state_next = STOP;
            STOP:    if (tick)                             state_next = IDLE;
            default:                                       state_next = IDLE;
        endcase
    end

    // Registered outputs are computed one cycle ahead of the line they drive.
    always_comb begin
        shreg_next   = shreg_reg;
        bit_idx_next = bit_idx_reg;
        txd_next     = txd_reg;
        rinc_next    = 1'b0;
        busy_next    = busy_reg;
        tx_done_next = 1'b0;
        case (state_reg)
            IDLE: begin
                txd_next = 1'b1;
                if (state_next == START) begin
                    shreg_next = rdata;
                    rinc_next  = 1'b1;
                    txd_next   = 1'b0;
                    busy_next  = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    bit_idx_next = '0;
                    txd_next     = shreg_reg[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx_reg == LAST_BIT) begin
                        txd_next     = 1'b1;
                        tx_done_next = (CLKS_PER_BIT == 1);
                    end else begin
                        shreg_next   = shreg_shift;
                        bit_idx_next = bit_idx_reg + 1'b1;
                        txd_next     = shreg_shift[0];
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    busy_next = 1'b0;
                end else begin
                    tx_done_next = pre_tick;
                end
            end
            default: begin
                txd_next  = 1'b1;
                busy_next = 1'b0;
            end
        endcase
    end

    assign rinc    = rinc_reg;
    assign txd     = txd_reg;
    assign busy    = busy_reg;
    assign tx_done = tx_done_reg;

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Bench for uart_fifo_tx: a CLKS_PER_BIT=4 and a CLKS_PER_BIT=1 instance, each
// fed by a FIFO model; expected words are queued on push and compared per frame.
module tb_uart_fifo_tx;

    logic       rclk   = 1'b0;
    logic       rrst_n = 1'b0;
    logic       tx_en  = 1'b0;
    logic       rempty_a = 1'b1, rempty_b = 1'b1;
    logic [7:0] rdata_a = 8'h00, rdata_b = 8'h00;
    logic       rinc_a, txd_a, busy_a, tx_done_a;
    logic       rinc_b, txd_b, busy_b, tx_done_b;

    logic [7:0] fq_a[$];
    logic [7:0] fq_b[$];
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    int         rinc_t_a[$];
    int         rinc_t_b[$];
    int         cyc      = 0;
    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 rclk = ~rclk;

    uart_fifo_tx #(.DATASIZE(8), .CLKS_PER_BIT(4)) dut_a (
        .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty_a), .rdata(rdata_a),
        .tx_en(tx_en), .rinc(rinc_a), .txd(txd_a), .busy(busy_a), .tx_done(tx_done_a)
    );

    uart_fifo_tx #(.DATASIZE(8), .CLKS_PER_BIT(1)) dut_b (
        .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty_b), .rdata(rdata_b),
        .tx_en(tx_en), .rinc(rinc_b), .txd(txd_b), .busy(busy_b), .tx_done(tx_done_b)
    );

    // FIFO models: pop on rinc, flags and head word refresh on the next edge.
    always @(posedge rclk) begin
        if (rinc_a && fq_a.size() > 0) void'(fq_a.pop_front());
        rempty_a <= (fq_a.size() == 0);
        rdata_a  <= (fq_a.size() > 0) ? fq_a[0] : 8'h00;
        if (rinc_b && fq_b.size() > 0) void'(fq_b.pop_front());
        rempty_b <= (fq_b.size() == 0);
        rdata_b  <= (fq_b.size() > 0) ? fq_b[0] : 8'h00;
        cyc <= cyc + 1;
    end

    always @(negedge rclk) begin
        if (rinc_a === 1'b1) rinc_t_a.push_back(cyc);
        if (rinc_b === 1'b1) rinc_t_b.push_back(cyc);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [39:0] build_wave(input logic [7:0] b, input int cpb);
        logic [39:0] w;
        logic        lvl;
        w = '0;
        for (int k = 0; k < 10; k++) begin
            if (k == 0)      lvl = 1'b0;
            else if (k == 9) lvl = 1'b1;
            else             lvl = b[k-1];
            for (int j = 0; j < cpb; j++) w[k*cpb+j] = lvl;
        end
        return w;
    endfunction

    task automatic push_word(input int u, input logic [7:0] w);
        if (u == 0) begin
            fq_a.push_back(w);
            exp_a.push_back(w);
        end else begin
            fq_b.push_back(w);
            exp_b.push_back(w);
        end
    endtask

    // Records one frame cycle by cycle, starting at the first sample with busy high.
    task automatic capture(input int u, output logic [39:0] wave, output logic [39:0] busy_m,
                           output logic [39:0] done_m, output logic [39:0] rinc_m,
                           output logic busy_after, output int waited, output logic timed_out);
        int len;
        len = (u == 0) ? 40 : 10;
        wave = '0; busy_m = '0; done_m = '0; rinc_m = '0;
        busy_after = 1'b0; waited = 0; timed_out = 1'b0;
        forever begin
            @(negedge rclk);
            waited++;
            if (((u == 0) ? busy_a : busy_b) === 1'b1) break;
            if (waited >= 200) begin
                timed_out = 1'b1;
                break;
            end
        end
        if (!timed_out) begin
            for (int c = 0; c < len; c++) begin
                if (c > 0) @(negedge rclk);
                wave[c]   = (u == 0) ? txd_a     : txd_b;
                busy_m[c] = (u == 0) ? busy_a    : busy_b;
                done_m[c] = (u == 0) ? tx_done_a : tx_done_b;
                rinc_m[c] = (u == 0) ? rinc_a    : rinc_b;
            end
            @(negedge rclk);
            busy_after = (u == 0) ? busy_a : busy_b;
        end
    endtask

    task automatic test_reset();
        int bad;
        int n0;
        bad = 0;
        rrst_n = 1'b0;
        tx_en  = 1'b0;
        repeat (3) @(negedge rclk);
        n_checks++; if (txd_a !== 1'b1) begin n_fail++; $display("FAIL reset_txd: got %b required 1", txd_a); end
        n_checks++; if (rinc_a !== 1'b0) begin n_fail++; $display("FAIL reset_rinc: got %b required 0", rinc_a); end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy_a); end
        n_checks++; if (tx_done_a !== 1'b0) begin n_fail++; $display("FAIL reset_tx_done: got %b required 0", tx_done_a); end
        n_checks++; if ({txd_b, rinc_b, busy_b, tx_done_b} !== 4'b1000) begin
            n_fail++; $display("FAIL reset_div1_outputs: got %b required 1000", {txd_b, rinc_b, busy_b, tx_done_b});
        end
        rrst_n = 1'b1;
        tx_en  = 1'b1;
        n0 = rinc_t_a.size();
        repeat (100) begin
            @(negedge rclk);
            if ({txd_a, rinc_a, busy_a, tx_done_a} !== 4'b1000) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL reset_idle_hold: %0d cycles left idle, required 0", bad); end
        n_checks++; if (rinc_t_a.size() != n0) begin
            n_fail++; $display("FAIL reset_no_pop: %0d pops while empty, required 0", rinc_t_a.size() - n0);
        end
        $display("txn reset: idle held for 100 cycles after release");
    endtask

    task automatic test_single_word();
        logic [39:0] w, bm, dm, rm;
        logic        ba, to;
        logic [7:0]  e;
        int          wt, n0;
        n0 = rinc_t_a.size();
        @(negedge rclk);
        push_word(0, 8'hA5);
        capture(0, w, bm, dm, rm, ba, wt, to);
        e = exp_a.pop_front();
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL single_start: no frame after %0d cycles, required one", wt); end
        n_checks++; if (w !== build_wave(e, 4)) begin n_fail++; $display("FAIL single_txd: got %h required %h", w, build_wave(e, 4)); end
        n_checks++; if (bm !== 40'hFF_FFFF_FFFF) begin n_fail++; $display("FAIL single_busy: got %h required ffffffffff", bm); end
        n_checks++; if (ba !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b after cycle 40, required 0", ba); end
        n_checks++; if (dm !== 40'h80_0000_0000) begin n_fail++; $display("FAIL single_tx_done: got %h required 8000000000", dm); end
        n_checks++; if (rm !== 40'h1) begin n_fail++; $display("FAIL single_rinc: got %h required 0000000001", rm); end
        repeat (5) @(negedge rclk);
        n_checks++; if (rinc_t_a.size() != n0 + 1) begin
            n_fail++; $display("FAIL single_pop_count: got %0d pops required 1", rinc_t_a.size() - n0);
        end
        $display("txn single: word %02h txd %h", e, w);
    endtask

    task automatic test_back_to_back();
        logic [39:0] w1, w2, bm, dm, rm;
        logic        ba, to1, to2;
        logic [7:0]  e1, e2;
        int          wt, n0, gap;
        n0 = rinc_t_a.size();
        @(negedge rclk);
        push_word(0, 8'h00);
        push_word(0, 8'hFF);
        capture(0, w1, bm, dm, rm, ba, wt, to1);
        e1 = exp_a.pop_front();
        $display("txn b2b_first: word %02h txd %h", e1, w1);
        capture(0, w2, bm, dm, rm, ba, wt, to2);
        e2 = exp_a.pop_front();
        $display("txn b2b_second: word %02h txd %h", e2, w2);
        n_checks++; if ({to1, to2} !== 2'b00) begin n_fail++; $display("FAIL b2b_start: timeouts %b required 00", {to1, to2}); end
        n_checks++; if (w1 !== build_wave(e1, 4)) begin n_fail++; $display("FAIL b2b_txd1: got %h required %h", w1, build_wave(e1, 4)); end
        n_checks++; if (w2 !== build_wave(e2, 4)) begin n_fail++; $display("FAIL b2b_txd2: got %h required %h", w2, build_wave(e2, 4)); end
        n_checks++; if (w2[35:4] !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL b2b_data_ones: got %h required ffffffff", w2[35:4]); end
        n_checks++; if (wt != 1) begin n_fail++; $display("FAIL b2b_idle_gap: second start %0d cycles after busy fell, required 1", wt); end
        gap = (rinc_t_a.size() == n0 + 2) ? (rinc_t_a[n0+1] - rinc_t_a[n0]) : -1;
        n_checks++; if (gap != 41) begin n_fail++; $display("FAIL b2b_rinc_gap: got %0d cycles required 41", gap); end
        n_checks++; if (rempty_a !== 1'b1) begin n_fail++; $display("FAIL b2b_rempty: got %b required 1", rempty_a); end
    endtask

    task automatic test_flow_control();
        logic [39:0] w, bm, dm, rm;
        logic        ba, to;
        logic [7:0]  e;
        int          wt, n0, bad;
        bad = 0;
        tx_en = 1'b0;
        n0 = rinc_t_a.size();
        @(negedge rclk);
        push_word(0, 8'h5A);
        push_word(0, 8'h33);
        repeat (200) begin
            @(negedge rclk);
            if (busy_a !== 1'b0) bad++;
        end
        n_checks++; if (rinc_t_a.size() != n0) begin
            n_fail++; $display("FAIL flow_disabled_pop: got %0d pops required 0", rinc_t_a.size() - n0);
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL flow_disabled_busy: busy for %0d cycles required 0", bad); end
        n0 = rinc_t_a.size();
        tx_en = 1'b1;
        fork
            capture(0, w, bm, dm, rm, ba, wt, to);
            begin
                repeat (10) @(negedge rclk);
                tx_en = 1'b0;
            end
        join
        e = exp_a.pop_front();
        $display("txn flow: word %02h txd %h", e, w);
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL flow_start: no frame after %0d cycles, required one", wt); end
        n_checks++; if (w !== build_wave(e, 4)) begin n_fail++; $display("FAIL flow_txd: got %h required %h", w, build_wave(e, 4)); end
        n_checks++; if (dm !== 40'h80_0000_0000) begin n_fail++; $display("FAIL flow_tx_done: got %h required 8000000000", dm); end
        repeat (100) @(negedge rclk);
        n_checks++; if (rinc_t_a.size() != n0 + 1) begin
            n_fail++; $display("FAIL flow_single_pop: got %0d pops required 1", rinc_t_a.size() - n0);
        end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL flow_idle_after: busy %b required 0", busy_a); end
    endtask

    task automatic test_reset_midframe();
        logic [39:0] w, bm, dm, rm;
        logic        ba, to;
        logic [7:0]  e, lost;
        int          wt, n;
        @(negedge rclk);
        push_word(0, 8'hC3);
        tx_en = 1'b1;
        n = 0;
        forever begin
            @(negedge rclk);
            n++;
            if (busy_a === 1'b1 || n >= 200) break;
        end
        n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL midrst_start: busy %b after %0d cycles, required 1", busy_a, n); end
        repeat (17) @(negedge rclk);
        // Frame cycle 18 is inside data bit 3, which is 0 for the pending word 0x33.
        n_checks++; if (txd_a !== 1'b0) begin n_fail++; $display("FAIL midrst_bit3: got %b required 0", txd_a); end
        rrst_n = 1'b0;
        #1;
        n_checks++; if ({txd_a, busy_a, rinc_a, tx_done_a} !== 4'b1000) begin
            n_fail++; $display("FAIL midrst_async: txd/busy/rinc/done %b required 1000", {txd_a, busy_a, rinc_a, tx_done_a});
        end
        lost = exp_a.pop_front();
        $display("txn midrst_lost: word %02h dropped by reset", lost);
        repeat (2) @(negedge rclk);
        rrst_n = 1'b1;
        capture(0, w, bm, dm, rm, ba, wt, to);
        e = exp_a.pop_front();
        $display("txn midrst_next: word %02h txd %h", e, w);
        n_checks++; if (wt != 1 || to !== 1'b0) begin n_fail++; $display("FAIL midrst_pop_latency: start after %0d cycles required 1", wt); end
        n_checks++; if (rm !== 40'h1) begin n_fail++; $display("FAIL midrst_rinc: got %h required 0000000001", rm); end
        n_checks++; if (w !== build_wave(e, 4)) begin n_fail++; $display("FAIL midrst_txd: got %h required %h", w, build_wave(e, 4)); end
        n_checks++; if (rempty_a !== 1'b1) begin n_fail++; $display("FAIL midrst_rempty: got %b required 1", rempty_a); end
    endtask

    task automatic test_min_divider();
        logic [39:0] w1, w2, bm, dm, rm;
        logic        ba, to1, to2;
        logic [7:0]  e1, e2;
        int          wt, n0, gap;
        tx_en = 1'b1;
        n0 = rinc_t_b.size();
        @(negedge rclk);
        push_word(1, 8'h3C);
        push_word(1, 8'h96);
        capture(1, w1, bm, dm, rm, ba, wt, to1);
        e1 = exp_b.pop_front();
        $display("txn div1_first: word %02h txd %h", e1, w1[9:0]);
        n_checks++; if (w1 !== build_wave(e1, 1)) begin n_fail++; $display("FAIL div1_txd1: got %h required %h", w1, build_wave(e1, 1)); end
        n_checks++; if (bm !== 40'h3FF || ba !== 1'b0) begin n_fail++; $display("FAIL div1_busy: got %h/%b required 3ff/0", bm, ba); end
        n_checks++; if (dm !== 40'h200) begin n_fail++; $display("FAIL div1_tx_done: got %h required 200", dm); end
        capture(1, w2, bm, dm, rm, ba, wt, to2);
        e2 = exp_b.pop_front();
        $display("txn div1_second: word %02h txd %h", e2, w2[9:0]);
        n_checks++; if ({to1, to2} !== 2'b00) begin n_fail++; $display("FAIL div1_start: timeouts %b required 00", {to1, to2}); end
        n_checks++; if (w2 !== build_wave(e2, 1)) begin n_fail++; $display("FAIL div1_txd2: got %h required %h", w2, build_wave(e2, 1)); end
        gap = (rinc_t_b.size() == n0 + 2) ? (rinc_t_b[n0+1] - rinc_t_b[n0]) : -1;
        n_checks++; if (gap != 11) begin n_fail++; $display("FAIL div1_rinc_gap: got %0d cycles required 11", gap); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_flow_control();
        test_reset_midframe();
        test_min_divider();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
